// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses PLL RST, waits for a stable synchronized lock,
// then releases the three clock-domain resets in a staggered order 0,1,2.
module pll_reset_sequencer #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 256,
   parameter int LOCK_STABLE  = 8,
   parameter int STAGGER      = 4,
   parameter int MAX_RETRIES  = 3
) (
   input  logic       clk,
   input  logic       cpu_reset,
   input  logic       pll_locked,
   input  logic       restart,
   output logic       pll_rst,
   output logic [2:0] domain_rst,
   output logic       ready,
   output logic       fail,
   output logic [2:0] retry_cnt
);

   localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CD  = (LOCK_STABLE > 2 * STAGGER) ? LOCK_STABLE : 2 * STAGGER;
   localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW      = $clog2(CNT_MAX + 1);

   // The cycle that detects lock already counts as the first stable cycle.
   localparam int STABLE_LAST_I = (LOCK_STABLE > 1) ? LOCK_STABLE - 2 : 0;

   localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_LAST_I);
   localparam logic [CW-1:0] RELEASE_LAST = CW'(2 * STAGGER - 1);
   localparam logic [CW-1:0] STAGGER_C    = CW'(STAGGER);
   localparam logic [2:0]    RETRY_LIMIT  = 3'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ASSERT_RST,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN,
      FAIL
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      retry_q, retry_d;
   logic            lockSync1_q, lockSync2_q;
   logic            pllRst_q, pllRst_d;
   logic [2:0]      domainRst_q, domainRst_d;
   logic            ready_q, ready_d;
   logic            fail_q, fail_d;
   logic            enter;
   logic            lockedS;
   logic [2:0]      retryInc;

   assign lockedS  = lockSync2_q;
   assign retryInc = retry_q + 3'd1;

   always_ff @(posedge clk) begin
      if (cpu_reset) begin
         state_q     <= ASSERT_RST;
         cnt_q       <= '0;
         retry_q     <= 3'd0;
         lockSync1_q <= 1'b0;
         lockSync2_q <= 1'b0;
         pllRst_q    <= 1'b1;
         domainRst_q <= 3'b111;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         lockSync1_q <= pll_locked;
         lockSync2_q <= lockSync1_q;
         pllRst_q    <= pllRst_d;
         domainRst_q <= domainRst_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
      end
   end

   // Restart outranks every in-state decision, including timeout and lock loss.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      enter   = 1'b0;
      if (restart) begin
         state_d = ASSERT_RST;
         retry_d = 3'd0;
         enter   = 1'b1;
      end else begin
         case (state_q)
            ASSERT_RST: begin
               if (cnt_q == RST_LAST) begin
                  state_d = WAIT_LOCK;
                  enter   = 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (lockedS) begin
                  if (LOCK_STABLE > 1) begin
                     state_d = STABLE;
                  end else begin
                     state_d = RELEASE;
                  end
                  enter = 1'b1;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  retry_d = retryInc;
                  if (retryInc == RETRY_LIMIT) begin
                     state_d = FAIL;
                  end else begin
                     state_d = ASSERT_RST;
                  end
                  enter = 1'b1;
               end
            end
            STABLE: begin
               if (!lockedS) begin
                  state_d = WAIT_LOCK;
                  enter   = 1'b1;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = RELEASE;
                  enter   = 1'b1;
               end
            end
            RELEASE: begin
               if (!lockedS) begin
                  state_d = ASSERT_RST;
                  enter   = 1'b1;
               end else if (cnt_q == RELEASE_LAST) begin
                  state_d = RUN;
                  retry_d = 3'd0;
                  enter   = 1'b1;
               end
            end
            RUN: begin
               if (!lockedS) begin
                  state_d = ASSERT_RST;
                  enter   = 1'b1;
               end
            end
            FAIL: begin
               state_d = FAIL;
            end
            default: begin
               state_d = ASSERT_RST;
               enter   = 1'b1;
            end
         endcase
      end
   end

   // RUN and FAIL have no timed exit, so the counter parks there instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (enter) begin
         cnt_d = '0;
      end else if (state_q != RUN && state_q != FAIL) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      pllRst_d    = 1'b0;
      domainRst_d = 3'b111;
      ready_d     = 1'b0;
      fail_d      = 1'b0;
      case (state_d)
         ASSERT_RST: pllRst_d = 1'b1;
         RELEASE:    domainRst_d = {1'b1, (cnt_d < STAGGER_C), 1'b0};
         RUN: begin
            domainRst_d = 3'b000;
            ready_d     = 1'b1;
         end
         FAIL: begin
            pllRst_d = 1'b1;
            fail_d   = 1'b1;
         end
         default: ;
      endcase
   end

   assign pll_rst    = pllRst_q;
   assign domain_rst = domainRst_q;
   assign ready      = ready_q;
   assign fail       = fail_q;
   assign retry_cnt  = retry_q;

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16, cycles pll_rst is held high per attempt (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 256, maximum cycles to wait for lock per attempt (>=1).
REQ-003 SHALL have parameter LOCK_STABLE, default 8, consecutive synchronized-lock cycles required before release (>=1).
REQ-004 SHALL have parameter STAGGER, default 4, cycles between successive domain reset releases (>=1).
REQ-005 SHALL have parameter MAX_RETRIES, default 3, failed lock attempts tolerated before FAIL (1..7).
REQ-006 SHALL have port clk, input, 1, single clock for all logic.
REQ-007 SHALL have port cpu_reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port pll_locked, input, 1, PLL LOCKED, asynchronous to clk.
REQ-009 SHALL have port restart, input, 1, single-cycle request to re-sequence the PLL.
REQ-010 SHALL have port pll_rst, output, 1, drives PLL RST.
REQ-011 SHALL have port domain_rst, output, 3, active-high resets for the CLKOUT0/1/2 domains, bit i for CLKOUTi.
REQ-012 SHALL have port ready, output, 1, high only in RUN.
REQ-013 SHALL have port fail, output, 1, high only in FAIL.
REQ-014 SHALL have port retry_cnt, output, 3, failed attempts since last RUN/restart/reset.

Function
REQ-015 SHALL synchronize pll_locked through two flops; locked_s = pll_locked delayed 2 clk cycles; all decisions use locked_s only.
REQ-016 SHALL implement states ASSERT_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL with one shared cycle counter, cleared on every state entry.
REQ-017 ASSERT_RST: pll_rst=1, domain_rst=3'b111; after exactly RST_CYCLES cycles -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE; else after LOCK_TIMEOUT cycles increment retry_cnt, then -> FAIL if new retry_cnt==MAX_RETRIES, otherwise -> ASSERT_RST.
REQ-019 STABLE: count consecutive locked_s=1 cycles; any locked_s=0 -> WAIT_LOCK (fresh timeout, retry_cnt unchanged); after LOCK_STABLE cycles -> RELEASE.
REQ-020 RELEASE: domain_rst[0] cleared on entry, domain_rst[1] STAGGER cycles later, domain_rst[2] 2*STAGGER cycles later; the cycle domain_rst[2] clears -> RUN; release order strictly 0,1,2.
REQ-021 RUN: ready=1, domain_rst=3'b000, retry_cnt cleared on entry.
REQ-022 RELEASE or RUN with locked_s=0 SHALL, in the next cycle, set domain_rst=3'b111, ready=0, and enter ASSERT_RST; retry_cnt unchanged.
REQ-023 FAIL: pll_rst=1, domain_rst=3'b111, fail=1; held until restart or cpu_reset.
REQ-024 restart=1 in any state SHALL enter ASSERT_RST next cycle with counter=0 and retry_cnt=0; restart takes priority over lock loss and timeout in the same cycle.
REQ-025 pll_rst, domain_rst, ready, fail SHALL be registered outputs (no combinational path from inputs).
REQ-026 Counter width SHALL cover max(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, 2*STAGGER) without wrap.

Reset
REQ-027 cpu_reset=1 SHALL, at the next clk edge, force state ASSERT_RST, counter=0, sync flops=0, retry_cnt=0, pll_rst=1, domain_rst=3'b111, ready=0, fail=0; cpu_reset overrides restart.
REQ-028 cpu_reset asserted mid-RELEASE or mid-RUN SHALL re-assert all domain resets at the next edge with no partial-release glitch.

Verification
REQ-029 Nominal (defaults): cpu_reset falls at cycle 0, pll_locked rises at cycle 20 -> pll_rst high cycles 0-15; domain_rst[0] clears cycle 30, [1] cycle 34, [2] and ready cycle 38.
REQ-030 Timeout: pll_locked held 0 -> three attempts of 16 cycles RST + 256 cycles WAIT; fail=1 after 816 cycles, retry_cnt=3, pll_rst=1.
REQ-031 Lock glitch in STABLE: pll_locked drops for 1 cycle 5 cycles after rising -> back to WAIT_LOCK, no domain release until 8 clean synchronized cycles, retry_cnt=0.
REQ-032 Lock loss in RUN: pll_locked falls -> 3 cycles later domain_rst=3'b111, ready=0, pll_rst=1 for 16 cycles, full re-sequence on relock.
REQ-033 restart in FAIL and restart coincident with lock loss in RUN -> ASSERT_RST next cycle, retry_cnt=0, fail=0.
REQ-034 cpu_reset pulsed while domain_rst=3'b100 -> domain_rst=3'b111, pll_rst=1 next edge, sequence restarts from REQ-029 timing.
